// File: rtl/csa_mult_pkg.sv
// Shared types and helpers for the sequential carry-save multiplier.
package csa_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPRESS,
        RESOLVE,
        HOLD
    } state_t;

    // Width of the compress-cycle counter; never narrower than one bit.
    function automatic int cnt_width(input int width, input int pp);
        int n;
        n = width / pp;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csa_row.sv
// N-bit 3:2 compressor row: one full adder per bit, carry returned unshifted.
module csa_row #(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ z[i];
        assign carry[i] = (x[i] & y[i]) | (x[i] & z[i]) | (y[i] & z[i]);
    end

endmodule

// File: rtl/csa_mult_seq.sv
// Sequential carry-save multiplier folding PP_PER_CYCLE partial products per cycle.
// Define CSA_MULT_ACC_EN to add the acc port and compute (a*b + acc) mod 2^(2*WIDTH).
module csa_mult_seq
    import csa_mult_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int PP_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef CSA_MULT_ACC_EN
    input  logic [2*WIDTH-1:0]   acc,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH, PP_PER_CYCLE);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH / PP_PER_CYCLE - 1);

    if (WIDTH < 2 || PP_PER_CYCLE < 1 || (WIDTH % PP_PER_CYCLE) != 0) begin : g_param_check
        $error("csa_mult_seq: WIDTH must be >= 2 and a multiple of PP_PER_CYCLE");
    end

    state_t           state;
    logic [PW-1:0]    a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [PW-1:0]    sum_q;
    logic [PW-1:0]    carry_q;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    sum_init;
    logic [PW-1:0]    sum_next;
    logic [PW-1:0]    carry_next;
    logic             take;

`ifdef CSA_MULT_ACC_EN
    assign sum_init = acc;
`else
    assign sum_init = '0;
`endif

    // Each row folds one partial product into the running sum/carry pair.
    for (genvar j = 0; j < PP_PER_CYCLE; j++) begin : g_row
        logic [PW-1:0] s_in;
        logic [PW-1:0] c_in;
        logic [PW-1:0] pp;
        logic [PW-1:0] rs;
        logic [PW-1:0] rc;
        logic [PW-1:0] c_out;

        if (j == 0) begin : g_first
            assign s_in = sum_q;
            assign c_in = carry_q;
        end else begin : g_next
            assign s_in = g_row[j-1].rs;
            assign c_in = g_row[j-1].c_out;
        end

        assign pp    = (a_sh << j) & {PW{b_sh[j]}};
        assign c_out = {rc[PW-2:0], 1'b0};

        csa_row #(.N(PW)) u_row (
            .x     (s_in),
            .y     (c_in),
            .z     (pp),
            .sum   (rs),
            .carry (rc)
        );
    end

    assign sum_next   = g_row[PP_PER_CYCLE-1].rs;
    assign carry_next = g_row[PP_PER_CYCLE-1].c_out;

    assign in_ready = rst_n & ((state == IDLE) | ((state == HOLD) & out_ready));
    assign take     = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            cnt       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else if (take) begin
            // A transfer from HOLD overlaps with the output handshake.
            state     <= COMPRESS;
            a_sh      <= {{WIDTH{1'b0}}, a};
            b_sh      <= b;
            sum_q     <= sum_init;
            carry_q   <= '0;
            cnt       <= CNT_INIT;
            out_valid <= 1'b0;
        end else begin
            case (state)
                COMPRESS: begin
                    sum_q   <= sum_next;
                    carry_q <= carry_next;
                    a_sh    <= a_sh << PP_PER_CYCLE;
                    b_sh    <= b_sh >> PP_PER_CYCLE;
                    cnt     <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    product   <= sum_q + carry_q;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_mult_seq.sv
// Bench for csa_mult_seq: directed cases on the default build plus a randomized
// parameter sweep checked against an arithmetic reference model.
module tb_csa_mult_seq;

    localparam int LAT = 8 / 2 + 1;
    localparam int NV  = 1000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
`ifdef CSA_MULT_ACC_EN
    logic [15:0] acc_d;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int n_cmp = 0;
    int n_err = 0;
    int sweep_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    csa_mult_seq #(.WIDTH(8), .PP_PER_CYCLE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef CSA_MULT_ACC_EN
        .acc       (acc_d),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    // Issue one operation from IDLE with out_ready high and check latency/result.
    task automatic mult_op(input logic [7:0] ia, input logic [7:0] ib,
                           input logic [15:0] iacc, input string tag);
        logic [31:0] full;
        logic [15:0] expv;
        int k;
        int e;
        full = 32'(ia) * 32'(ib) + 32'(iacc);
        expv = full[15:0];
        in_valid  = 1'b1;
        a         = ia;
        b         = ib;
        out_ready = 1'b1;
`ifdef CSA_MULT_ACC_EN
        acc_d     = iacc;
`endif
        #1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check_val({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        e = 0;
        while (!out_valid && e < 20) begin
            @(posedge clk); #1; e++;
        end
        check_val({tag, " latency"}, 64'(e), 64'(LAT));
        check_val({tag, " product"}, 64'(product), 64'(expv));
        @(posedge clk); #1;
        check_val({tag, " valid pulse"}, 64'(out_valid), 64'd0);
    endtask

    initial begin : directed
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
`ifdef CSA_MULT_ACC_EN
        acc_d     = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_val("rst out_valid", 64'(out_valid), 64'd0);
        check_val("rst product", 64'(product), 64'd0);
        check_val("rst in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check_val("idle in_ready", 64'(in_ready), 64'd1);

        mult_op(8'd3, 8'd5, 16'd0, "basic");
        mult_op(8'hFF, 8'hFF, 16'd0, "max");
        mult_op(8'h00, 8'hFF, 16'd0, "zero");

        // Backpressure, then an overlapped accept from HOLD.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'd9;
        b = 8'd9;
        @(posedge clk); #1;
        a = 8'hFF;
        b = 8'hFF;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check_val("bp latency", 64'(k), 64'(LAT));
        for (int i = 0; i < 10; i++) begin
            check_val("bp product", 64'(product), 64'd81);
            check_val("bp out_valid", 64'(out_valid), 64'd1);
            check_val("bp in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        a = 8'd2;
        b = 8'd7;
        out_ready = 1'b1;
        #1;
        check_val("overlap in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("overlap valid drop", 64'(out_valid), 64'd0);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check_val("overlap latency", 64'(k), 64'(LAT));
        check_val("overlap product", 64'(product), 64'h000E);
        @(posedge clk); #1;

        // Reset during the second COMPRESS cycle.
        in_valid = 1'b1;
        a = 8'hAB;
        b = 8'hCD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst out_valid", 64'(out_valid), 64'd0);
        check_val("midrst in_ready", 64'(in_ready), 64'd0);
        check_val("midrst product", 64'(product), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_val("midrst release in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_val("midrst no valid", 64'(out_valid), 64'd0);
        end
        mult_op(8'd10, 8'd10, 16'd0, "after rst");

`ifdef CSA_MULT_ACC_EN
        mult_op(8'hFF, 8'hFF, 16'h01FF, "acc wrap");
        mult_op(8'h00, 8'h00, 16'hABCD, "acc only");
`endif

        k = 0;
        while (sweep_done < 6 && k < 60000) begin
            @(posedge clk); k++;
        end
        check_val("sweep complete", 64'(sweep_done), 64'd6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    localparam int SW [6] = '{8, 8, 8, 16, 16, 16};
    localparam int SP [6] = '{1, 4, 8, 1, 4, 8};

    for (genvar g = 0; g < 6; g++) begin : g_sweep
        localparam int W = SW[g];
        localparam int P = SP[g];
        localparam int N = W / P;

        logic           s_rst_n;
        logic           s_in_valid;
        logic           s_in_ready;
        logic [W-1:0]   s_a;
        logic [W-1:0]   s_b;
`ifdef CSA_MULT_ACC_EN
        logic [2*W-1:0] s_acc;
`endif
        logic           s_out_valid;
        logic           s_out_ready;
        logic [2*W-1:0] s_product;

        csa_mult_seq #(.WIDTH(W), .PP_PER_CYCLE(P)) u_dut (
            .clk       (clk),
            .rst_n     (s_rst_n),
            .in_valid  (s_in_valid),
            .in_ready  (s_in_ready),
            .a         (s_a),
            .b         (s_b),
`ifdef CSA_MULT_ACC_EN
            .acc       (s_acc),
`endif
            .out_valid (s_out_valid),
            .out_ready (s_out_ready),
            .product   (s_product)
        );

        initial begin : stim
            bit          pend;
            bit          ev;
            bit          er;
            int          acc_it;
            int          iter;
            int          done;
            logic [63:0] expp;
            logic [63:0] mask;
            string       pfx;
            pfx  = $sformatf("w%0d_pp%0d", W, P);
            mask = (64'd1 << (2 * W)) - 64'd1;
            pend = 1'b0;
            acc_it = 0;
            iter = 0;
            done = 0;
            expp = '0;
            s_rst_n     = 1'b0;
            s_in_valid  = 1'b0;
            s_out_ready = 1'b0;
            s_a = '0;
            s_b = '0;
`ifdef CSA_MULT_ACC_EN
            s_acc = '0;
`endif
            repeat (3) @(posedge clk);
            #1;
            check_val({pfx, " rst out_valid"}, 64'(s_out_valid), 64'd0);
            check_val({pfx, " rst in_ready"}, 64'(s_in_ready), 64'd0);
            s_rst_n = 1'b1;
            while (done < NV && iter < 50000) begin
                @(negedge clk);
                s_in_valid  = ($urandom_range(3) != 0);
                s_a         = W'($urandom);
                s_b         = W'($urandom);
                s_out_ready = ($urandom_range(1) == 1);
`ifdef CSA_MULT_ACC_EN
                s_acc       = (2*W)'($urandom);
`endif
                #1;
                ev = pend && (iter >= acc_it + N + 2);
                er = !pend || (ev && s_out_ready);
                check_val({pfx, " out_valid"}, 64'(s_out_valid), 64'(ev));
                check_val({pfx, " in_ready"}, 64'(s_in_ready), 64'(er));
                if (ev) begin
                    check_val({pfx, " product"}, 64'(s_product), expp);
                end
                if (ev && s_out_ready) begin
                    pend = 1'b0;
                    done++;
                end
                if (s_in_valid && er) begin
                    pend   = 1'b1;
                    acc_it = iter;
`ifdef CSA_MULT_ACC_EN
                    expp = (64'(s_a) * 64'(s_b) + 64'(s_acc)) & mask;
`else
                    expp = (64'(s_a) * 64'(s_b)) & mask;
`endif
                end
                iter++;
            end
            check_val({pfx, " vectors done"}, 64'(done), 64'(NV));
            sweep_done++;
        end
    end

endmodule
